top_varint_encoder: RTL and testbench



---
 rtl/varint_pkg.sv | 20 ++
 rtl/varint_if.sv | 20 ++
 rtl/varint_enc.sv | 28 ++
 rtl/top_varint_encoder.sv | 74 +++++++
 tb/tb_top_varint_encoder.sv | 124 ++++++++++++
 5 files changed

// File: rtl/varint_pkg.sv
// Shared constants for the protobuf varint field encoder: descriptor type codes,
// the varint wire type, and the byte budgets of the tag and value varints.
package varint_pkg;

  typedef enum logic [4:0] {
    FT_INT64  = 5'd3,
    FT_UINT64 = 5'd4,
    FT_INT32  = 5'd5,
    FT_BOOL   = 5'd8,
    FT_UINT32 = 5'd13,
    FT_ENUM   = 5'd14,
    FT_SINT32 = 5'd17,
    FT_SINT64 = 5'd18
  } field_type_e;

  localparam logic [2:0] WIRE_TYPE_VARINT = 3'd0;
  localparam int MAX_TAG_BYTES = 5;
  localparam int MAX_VAL_BYTES = 10;

endpackage

// File: rtl/varint_if.sv
// Request/response bundle between the field sequencer and the varint encoder.
interface varint_if;
  logic         in_valid;
  logic [63:0]  value;
  logic [28:0]  field_id;
  logic [4:0]   field_type;
  logic         out_valid;
  logic [3:0]   out_len;
  logic [119:0] out_port;

  modport master (
    output in_valid, value, field_id, field_type,
    input  out_valid, out_len, out_port
  );

  modport slave (
    input  in_valid, value, field_id, field_type,
    output out_valid, out_len, out_port
  );
endinterface

// File: rtl/varint_enc.sv
// Combinational 64-bit varint encoder: byte 0 lands in [79:72], unused trailing
// bytes are zero, and len is the number of emitted bytes (always at least 1).
module varint_enc
  import varint_pkg::*;
(
  input  logic [63:0] v,
  output logic [79:0] bytes_out,
  output logic [3:0]  len
);

  // Length is one past the highest 7-bit group that still holds a set bit.
  always_comb begin
    len = 4'd1;
    for (int i = 1; i < MAX_VAL_BYTES; i++) begin
      if ((v >> (7 * i)) != 64'd0) len = 4'(i + 1);
    end
  end

  always_comb begin
    bytes_out = '0;
    for (int i = 0; i < MAX_VAL_BYTES; i++) begin
      if (4'(i) < len) begin
        bytes_out[79 - 8 * i -: 8] = {(4'(i + 1) < len), 7'(v >> (7 * i))};
      end
    end
  end

endmodule

// File: rtl/top_varint_encoder.sv
// Protobuf varint field encoder: normalises the value by descriptor type, encodes
// tag and value varints, packs them left-justified and registers the result.
module top_varint_encoder
  import varint_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  varint_if.slave bus
);

  logic [63:0]  norm_value;
  logic         supported;
  logic [63:0]  tag_word;
  logic [79:0]  tag_bytes;
  logic [79:0]  val_bytes;
  logic [3:0]   tag_len;
  logic [3:0]   val_len;
  logic [119:0] packed_bytes;
  logic [3:0]   packed_len;

  always_comb begin
    norm_value = '0;
    supported  = 1'b1;
    case (bus.field_type)
      FT_INT64, FT_UINT64: norm_value = bus.value;
      FT_INT32, FT_ENUM:   norm_value = {{32{bus.value[31]}}, bus.value[31:0]};
      FT_UINT32:           norm_value = {32'd0, bus.value[31:0]};
      FT_BOOL:             norm_value = {63'd0, |bus.value};
      FT_SINT32:           norm_value = {32'd0, {bus.value[30:0], 1'b0} ^ {32{bus.value[31]}}};
      FT_SINT64:           norm_value = {bus.value[62:0], 1'b0} ^ {64{bus.value[63]}};
      default:             supported  = 1'b0;
    endcase
  end

  assign tag_word = {32'd0, bus.field_id, WIRE_TYPE_VARINT};

  varint_enc u_tag_enc (
    .v         (tag_word),
    .bytes_out (tag_bytes),
    .len       (tag_len)
  );

  varint_enc u_val_enc (
    .v         (norm_value),
    .bytes_out (val_bytes),
    .len       (val_len)
  );

  // A 32-bit tag never exceeds five bytes, so tag_bytes[39:0] is always zero and
  // the value bytes slide in directly behind the last tag byte.
  always_comb begin
    packed_bytes = '0;
    packed_len   = '0;
    if (supported) begin
      packed_bytes = {tag_bytes, 40'd0} | ({val_bytes, 40'd0} >> {tag_len, 3'b000});
      packed_len   = tag_len + val_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_len   <= '0;
      bus.out_port  <= '0;
    end else if (bus.in_valid) begin
      bus.out_valid <= 1'b1;
      bus.out_len   <= packed_len;
      bus.out_port  <= packed_bytes;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_top_varint_encoder.sv
// Directed-vector bench for the varint field encoder with hand-computed results.
module tb_top_varint_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  varint_if bus ();

  top_varint_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] v, input logic [28:0] id,
                                input logic [4:0] t);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.value      = v;
    bus.field_id   = id;
    bus.field_type = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input string name, input logic [63:0] v, input logic [28:0] id,
                            input logic [4:0] t, input logic [3:0] exp_len,
                            input logic [119:0] exp_port);
    apply_stimulus(v, id, t);
    check_output({name, ".valid"}, 128'(bus.out_valid), 128'(1'b1));
    check_output({name, ".len"},   128'(bus.out_len),   128'(exp_len));
    check_output({name, ".port"},  128'(bus.out_port),  128'(exp_port));
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.value      = '0;
    bus.field_id   = '0;
    bus.field_type = '0;
    #12;
    check_output("reset.valid", 128'(bus.out_valid), 128'(0));
    check_output("reset.len",   128'(bus.out_len),   128'(0));
    check_output("reset.port",  128'(bus.out_port),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_vector("int32_150",   64'd150, 29'd1, 5'd5, 4'd3, 120'h089601 << 96);
    run_vector("sint64_m2",   64'hFFFF_FFFF_FFFF_FFFE, 29'd2, 5'd18, 4'd2, 120'h1003 << 104);
    run_vector("int64_max",   64'hFFFF_FFFF_FFFF_FFFF, 29'h1FFF_FFFF, 5'd3, 4'd15,
               120'hF8FFFFFF0F_FFFFFFFFFFFFFFFFFF01);
    run_vector("int32_zero",  64'd0, 29'd1, 5'd5, 4'd2, 120'h0800 << 104);
    run_vector("bool_5",      64'd5, 29'd1, 5'd8, 4'd2, 120'h0801 << 104);
    run_vector("double",      64'd1234, 29'd7, 5'd1, 4'd0, 120'd0);
    run_vector("int32_m1",    64'hFFFF_FFFF_FFFF_FFFF, 29'd1, 5'd5, 4'd11,
               120'h08FFFFFFFFFFFFFFFFFF01 << 32);
    run_vector("uint32_wide", 64'hFFFF_FFFF_FFFF_FFFF, 29'd1, 5'd13, 4'd6,
               120'h08FFFFFFFF0F << 72);
    run_vector("sint32_m1",   64'hFFFF_FFFF_FFFF_FFFF, 29'd16, 5'd17, 4'd3, 120'h800101 << 96);
    run_vector("uint64_300",  64'd300, 29'd15, 5'd4, 4'd3, 120'h78AC02 << 96);
    run_vector("enum_1",      64'd1, 29'd3, 5'd14, 4'd2, 120'h1801 << 104);
    run_vector("uint32_1",    64'h1_0000_0001, 29'd1, 5'd13, 4'd2, 120'h0801 << 104);

    // Idle cycle: valid drops while data holds the last result.
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.value      = 64'd99;
    bus.field_type = 5'd4;
    @(posedge clk);
    #1;
    check_output("idle.valid", 128'(bus.out_valid), 128'(0));
    check_output("idle.len",   128'(bus.out_len),   128'(2));
    check_output("idle.port",  128'(bus.out_port),  128'(120'h0801 << 104));

    // Reset asserted mid-stream must clear outputs before any clock edge.
    apply_stimulus(64'd150, 29'd1, 5'd5);
    apply_stimulus(64'd300, 29'd15, 5'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async.valid", 128'(bus.out_valid), 128'(0));
    check_output("async.len",   128'(bus.out_len),   128'(0));
    check_output("async.port",  128'(bus.out_port),  128'(0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid   = 1'b1;
    bus.value      = 64'hFFFF_FFFF_FFFF_FFFE;
    bus.field_id   = 29'd2;
    bus.field_type = 5'd18;
    #1;
    check_output("post.before_edge", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    check_output("post.valid", 128'(bus.out_valid), 128'(1));
    check_output("post.len",   128'(bus.out_len),   128'(2));
    check_output("post.port",  128'(bus.out_port),  128'(120'h1003 << 104));
    @(negedge clk);
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
